dut_result_checker: RTL and testbench
=====================================

# dut_result_checker

Compares each DUT result word from the DUT interface stage against an expected word and mask from the expected-data FIFO. Counts vectors and mismatches, records the index of the first failure, and pushes one fail record per mismatching vector into the fail FIFO. Sits directly downstream of the DUT interface stage, in the same gated clock domain. When the result path stalls the clock, this block stalls with it, so no result is lost.

## Interface
- RTF_WIDTH, 24, width of a DUT result word
- CNT_WIDTH, 16, width of the vector index and counters
- EXP_WIDTH, 2*RTF_WIDTH, expected FIFO word: {mask, expected}
- FAIL_WIDTH, CNT_WIDTH+RTF_WIDTH, fail record: {vector index, result}

Ports:
- clock_gated  in  1  clock, shared with the DUT interface stage
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: clear all state and begin a run
- total_vectors  in  CNT_WIDTH  number of vectors in the run; sampled on start
- res_valid  in  1  result word valid (the DUT interface result write strobe)
- res_data  in  RTF_WIDTH  DUT result word
- exp_data  in  EXP_WIDTH  expected FIFO head (show-ahead)
- exp_rdreq  out  1  expected FIFO pop
- exp_rdempty  in  1  expected FIFO empty
- fail_data  out  FAIL_WIDTH  fail record
- fail_wrreq  out  1  fail FIFO push
- fail_wrfull  in  1  fail FIFO full
- busy  out  1  in state RUN
- done  out  1  in state DONE
- vec_count  out  CNT_WIDTH  vectors compared
- fail_count  out  CNT_WIDTH  mismatching vectors, saturating
- first_fail_idx  out  CNT_WIDTH  index of the first mismatch; all ones if none
- exp_underflow  out  1  sticky: a result arrived while the expected FIFO was empty
- fail_overflow  out  1  sticky: a fail record was dropped because the fail FIFO was full

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE or DONE, start=1: go to RUN.
  - Latch total_vectors.
  - Clear vec_count, fail_count and both sticky flags.
  - Set first_fail_idx to all ones.
  - Flush pipeline valids.
- RUN, start=1: restart with identical clearing and stay in RUN.
- Results are accepted only in RUN, and only while the accepted count (including in-flight entries) is below total_vectors.
  - Other res_valid pulses are ignored: no pop, no count.
- Stage 1, on an accepted res_valid:
  - exp_rdreq = res_valid & ~exp_rdempty, combinational, same cycle.
  - Register res_data, exp_data, the current index and a valid bit.
  - If exp_rdempty=1: set the stage-1 underflow bit, force the mask to all ones and the expected word to the bitwise inverse of res_data. The comparison therefore fails. Set exp_underflow.
- Stage 2, on stage-1 valid:
  - mismatch = |((res ^ exp) & mask).
  - Increment vec_count.
  - If mismatch:
    - Increment fail_count; hold at all ones.
    - If first_fail_idx is all ones, set it to the index.
    - If fail_wrfull=0, push {index, res}; otherwise drop the record and set fail_overflow.
- RUN to DONE when vec_count reaches total_vectors and both stages are empty.
- total_vectors=0: RUN to DONE on the cycle after start.
- DONE holds every counter and flag until the next start.

## Timing
- Reset values:
  - Outputs: exp_rdreq=0, fail_wrreq=0, fail_data=0, busy=0, done=0, vec_count=0, fail_count=0, exp_underflow=0, fail_overflow=0.
  - first_fail_idx: all ones.
  - Internal: state IDLE, both pipeline valids 0.
- Latency from res_valid at edge N:
  - fail_wrreq and fail_data are registered and asserted for the cycle after edge N+2.
  - vec_count updates at edge N+2.
- Throughput: one vector per clock, with back-to-back res_valid supported.
- fail_wrreq is a single-cycle pulse per record, never asserted while fail_wrfull=1.
- No exp_rdreq while exp_rdempty=1.
- start on the same cycle as res_valid: start wins; that result is ignored and not popped.
- A clock stall (gated clock) freezes all state; no action is required from this block.
- reset_n asserted mid-run returns everything to reset values immediately, including a fail_wrreq in flight.

## Test plan
- 4-vector run, all results equal to expected, mask 0xFFFFFF:
  - 4 exp pops, vec_count=4, fail_count=0, first_fail_idx=0xFFFF, no fail_wrreq.
  - done=1 three cycles after the last res_valid.
- 4-vector run; vector 2 has result 0x000010, expected 0x000000:
  - With mask 0x0000FF: one fail record {2, 0x000010}, fail_count=1, first_fail_idx=2.
  - With mask 0xFFFF00: no fail.
- 3 back-to-back results, exp FIFO empty from vector 1:
  - exp_underflow=1, fail_count=2, first_fail_idx=1, exp_rdreq pulsed once only.
- Every vector mismatches while fail_wrfull=1 for vectors 1-2 of 4:
  - 2 records pushed (indices 0 and 3), fail_count=4, fail_overflow=1.
- start reasserted mid-run after 2 of 5 vectors:
  - Counters clear, the run continues to 5 new vectors, then done=1.
  - Extra res_valid pulses in DONE cause no pops.
- reset_n pulsed low while a mismatch sits in stage 1:
  - No fail_wrreq follows; all outputs return to reset values; state IDLE.

Source files
------------

// File: rtl/dut_result_checker.sv
// Compares DUT result words against expected/mask words from the expected FIFO,
// counts vectors and mismatches, and pushes one fail record per mismatching vector.
module dut_result_checker #(
    parameter int RTF_WIDTH  = 24,
    parameter int CNT_WIDTH  = 16,
    parameter int EXP_WIDTH  = 2*RTF_WIDTH,
    parameter int FAIL_WIDTH = CNT_WIDTH+RTF_WIDTH
) (
    input  logic                  clock_gated,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  total_vectors,
    input  logic                  res_valid,
    input  logic [RTF_WIDTH-1:0]  res_data,
    input  logic [EXP_WIDTH-1:0]  exp_data,
    output logic                  exp_rdreq,
    input  logic                  exp_rdempty,
    output logic [FAIL_WIDTH-1:0] fail_data,
    output logic                  fail_wrreq,
    input  logic                  fail_wrfull,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  vec_count,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic [CNT_WIDTH-1:0]  first_fail_idx,
    output logic                  exp_underflow,
    output logic                  fail_overflow
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [CNT_WIDTH-1:0] CNT_ONES = '1;

    state_t                state;
    logic [CNT_WIDTH-1:0]  total_q;
    logic [CNT_WIDTH-1:0]  acc_count;
    logic [2:1]            vld_pipe;
    logic [RTF_WIDTH-1:0]  s1_res, s1_exp, s1_mask, s2_res;
    logic [CNT_WIDTH-1:0]  s1_idx, s2_idx;
    logic                  s1_unf, s2_mis;
    logic                  accept;

    // acc_count includes in-flight entries so the run never over-accepts
    assign accept    = (state == RUN) && !start && res_valid && (acc_count < total_q);
    assign exp_rdreq = accept && !exp_rdempty;

    always_ff @(posedge clock_gated or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            total_q        <= '0;
            acc_count      <= '0;
            vld_pipe       <= '0;
            s1_res         <= '0;
            s1_exp         <= '0;
            s1_mask        <= '0;
            s1_idx         <= '0;
            s1_unf         <= 1'b0;
            s2_res         <= '0;
            s2_idx         <= '0;
            s2_mis         <= 1'b0;
            vec_count      <= '0;
            fail_count     <= '0;
            first_fail_idx <= CNT_ONES;
            exp_underflow  <= 1'b0;
            fail_overflow  <= 1'b0;
            fail_wrreq     <= 1'b0;
            fail_data      <= '0;
        end else begin
            fail_wrreq <= 1'b0;
            if (start) begin
                state          <= RUN;
                busy           <= 1'b1;
                done           <= 1'b0;
                total_q        <= total_vectors;
                acc_count      <= '0;
                vld_pipe       <= '0;
                vec_count      <= '0;
                fail_count     <= '0;
                first_fail_idx <= CNT_ONES;
                exp_underflow  <= 1'b0;
                fail_overflow  <= 1'b0;
            end else begin
                vld_pipe[1] <= accept;
                if (accept) begin
                    acc_count <= acc_count + 1'b1;
                    s1_res    <= res_data;
                    s1_idx    <= acc_count;
                    s1_unf    <= exp_rdempty;
                    // no expected word: force a guaranteed miscompare
                    if (exp_rdempty) begin
                        s1_exp        <= ~res_data;
                        s1_mask       <= '1;
                        exp_underflow <= 1'b1;
                    end else begin
                        s1_exp  <= exp_data[RTF_WIDTH-1:0];
                        s1_mask <= exp_data[2*RTF_WIDTH-1:RTF_WIDTH];
                    end
                end

                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    s2_mis <= s1_unf | (|((s1_res ^ s1_exp) & s1_mask));
                    s2_res <= s1_res;
                    s2_idx <= s1_idx;
                end

                if (vld_pipe[2]) begin
                    vec_count <= vec_count + 1'b1;
                    if (s2_mis) begin
                        if (fail_count != CNT_ONES)
                            fail_count <= fail_count + 1'b1;
                        if (first_fail_idx == CNT_ONES)
                            first_fail_idx <= s2_idx;
                        if (!fail_wrfull) begin
                            fail_wrreq <= 1'b1;
                            fail_data  <= {s2_idx, s2_res};
                        end else begin
                            fail_overflow <= 1'b1;
                        end
                    end
                end

                if (state == RUN && vld_pipe == '0 && vec_count == total_q) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dut_result_checker.sv
// Scoreboard bench for dut_result_checker: expected FIFO model, fail-record queue,
// counter/flag checks per scenario.
module tb_dut_result_checker;
    localparam int RW = 24;
    localparam int CW = 16;
    localparam int EW = 2*RW;
    localparam int FW = CW+RW;

    logic          clock_gated = 1'b0;
    logic          reset_n     = 1'b0;
    logic          start       = 1'b0;
    logic [CW-1:0] total_vectors = '0;
    logic          res_valid   = 1'b0;
    logic [RW-1:0] res_data    = '0;
    logic [EW-1:0] exp_data    = '0;
    logic          exp_rdreq;
    logic          exp_rdempty = 1'b1;
    logic [FW-1:0] fail_data;
    logic          fail_wrreq;
    logic          fail_wrfull = 1'b0;
    logic          busy, done;
    logic [CW-1:0] vec_count, fail_count, first_fail_idx;
    logic          exp_underflow, fail_overflow;

    dut_result_checker dut (
        .clock_gated(clock_gated), .reset_n(reset_n), .start(start),
        .total_vectors(total_vectors), .res_valid(res_valid), .res_data(res_data),
        .exp_data(exp_data), .exp_rdreq(exp_rdreq), .exp_rdempty(exp_rdempty),
        .fail_data(fail_data), .fail_wrreq(fail_wrreq), .fail_wrfull(fail_wrfull),
        .busy(busy), .done(done), .vec_count(vec_count), .fail_count(fail_count),
        .first_fail_idx(first_fail_idx), .exp_underflow(exp_underflow),
        .fail_overflow(fail_overflow)
    );

    always #5 clock_gated = ~clock_gated;

    typedef struct {
        logic [FW-1:0] rec;
        int            cyc;
    } sb_t;

    sb_t           sb[$];
    logic [EW-1:0] expq[$];
    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            pops = 0;
    logic [CW-1:0] idx = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_chk++;
        if (obs !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, req);
        end
    endtask

    always @(posedge clock_gated) cyc++;

    // expected FIFO model: show-ahead head, popped just after the edge that saw exp_rdreq
    always @(posedge clock_gated) begin
        logic pend;
        pend = exp_rdreq;
        #1;
        if (pend && expq.size() > 0) void'(expq.pop_front());
        exp_rdempty = (expq.size() == 0);
        exp_data    = (expq.size() == 0) ? '0 : expq[0];
    end

    // fail-record monitor and per-cycle protocol checks
    always @(negedge clock_gated) begin
        static logic prev_full = 1'b0;
        sb_t e;
        if (exp_rdreq) pops++;
        if (exp_rdempty) chk("rdreq_while_empty", exp_rdreq, 0);
        if (fail_wrreq) begin
            chk("wrreq_after_full", prev_full, 0);
            if (sb.size() == 0) begin
                chk("fail_unexpected", fail_wrreq, 0);
            end else begin
                e = sb.pop_front();
                chk("fail_rec", fail_data, e.rec);
                chk("fail_lat", cyc, e.cyc);
            end
        end
        prev_full = fail_wrfull;
    end

    task automatic tick();
        @(posedge clock_gated);
        #1;
    endtask

    task automatic do_start(input logic [CW-1:0] n);
        start = 1'b1;
        total_vectors = n;
        tick();
        start = 1'b0;
        idx = '0;
    endtask

    task automatic send(input logic [RW-1:0] res, input logic [RW-1:0] ex,
                        input logic [RW-1:0] mk, input bit have, input bit drop);
        sb_t e;
        logic mis;
        mis = have ? (|((res ^ ex) & mk)) : 1'b1;
        res_valid = 1'b1;
        res_data  = res;
        if (mis && !drop) begin
            e.rec = {idx, res};
            e.cyc = cyc + 3;
            sb.push_back(e);
        end
        idx++;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int k = 0;
        while (!done && k < lim) begin
            tick();
            k++;
        end
        chk("done_reached", done, 1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_rdreq", exp_rdreq, 0);
        chk("rst_wrreq", fail_wrreq, 0);
        chk("rst_fdata", fail_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_vec", vec_count, 0);
        chk("rst_fcnt", fail_count, 0);
        chk("rst_first", first_fail_idx, 16'hFFFF);
        chk("rst_unf", exp_underflow, 0);
        chk("rst_ovf", fail_overflow, 0);
    endtask

    initial begin
        int p0;
        logic [RW-1:0] r;

        tick(); tick();
        chk_reset_vals();
        reset_n = 1'b1;
        tick();

        // 4 matching vectors, full mask; done three cycles after last result
        for (int i = 0; i < 4; i++) expq.push_back({24'hFFFFFF, 24'h5A0000 + 24'(i)});
        p0 = pops;
        do_start(4);
        chk("t1_busy", busy, 1);
        for (int i = 0; i < 4; i++) send(24'h5A0000 + 24'(i), 24'h5A0000 + 24'(i), 24'hFFFFFF, 1, 0);
        chk("t1_done_n1", done, 0);
        tick(); chk("t1_done_n2", done, 0);
        tick(); chk("t1_done_n3", done, 0); chk("t1_vec_early", vec_count, 4);
        tick(); chk("t1_done", done, 1);
        chk("t1_pops", pops - p0, 4);
        chk("t1_fcnt", fail_count, 0);
        chk("t1_first", first_fail_idx, 16'hFFFF);
        chk("t1_busy_end", busy, 0);

        // masked compare: 0x0000FF catches bit 4, 0xFFFF00 hides it
        for (int m = 0; m < 2; m++) begin
            logic [RW-1:0] mk;
            mk = (m == 0) ? 24'h0000FF : 24'hFFFF00;
            for (int i = 0; i < 4; i++) expq.push_back({mk, (i == 2) ? 24'h000000 : 24'h00AB00 + 24'(i)});
            do_start(4);
            for (int i = 0; i < 4; i++) begin
                r = (i == 2) ? 24'h000010 : 24'h00AB00 + 24'(i);
                send(r, (i == 2) ? 24'h000000 : 24'h00AB00 + 24'(i), mk, 1, 0);
            end
            wait_done(20);
            chk("t2_vec", vec_count, 4);
            chk("t2_fcnt", fail_count, (m == 0) ? 1 : 0);
            chk("t2_first", first_fail_idx, (m == 0) ? 16'd2 : 16'hFFFF);
            chk("t2_sb_empty", sb.size(), 0);
        end

        // expected FIFO runs dry after vector 0
        expq.push_back({24'hFFFFFF, 24'h111111});
        tick();
        p0 = pops;
        do_start(3);
        send(24'h111111, 24'h111111, 24'hFFFFFF, 1, 0);
        send(24'h222222, 24'h0, 24'h0, 0, 0);
        send(24'h333333, 24'h0, 24'h0, 0, 0);
        wait_done(20);
        chk("t3_unf", exp_underflow, 1);
        chk("t3_fcnt", fail_count, 2);
        chk("t3_first", first_fail_idx, 1);
        chk("t3_pops", pops - p0, 1);
        chk("t3_sb_empty", sb.size(), 0);

        // all mismatch, fail FIFO full while vectors 1-2 retire
        for (int i = 0; i < 4; i++) expq.push_back({24'hFFFFFF, 24'h000000});
        do_start(4);
        for (int c = 0; c < 6; c++) begin
            fail_wrfull = (c == 3 || c == 4);
            if (c < 4) send(24'hC00000 + 24'(c), 24'h0, 24'hFFFFFF, 1, (c == 1 || c == 2));
            else tick();
        end
        fail_wrfull = 1'b0;
        wait_done(20);
        chk("t4_fcnt", fail_count, 4);
        chk("t4_ovf", fail_overflow, 1);
        chk("t4_first", first_fail_idx, 0);
        chk("t4_vec", vec_count, 4);
        chk("t4_sb_empty", sb.size(), 0);

        // restart mid-run after 2 of 5, with a result on the start cycle
        for (int i = 0; i < 9; i++) expq.push_back({24'hFFFFFF, 24'h0A0000 + 24'(i)});
        tick();
        p0 = pops;
        do_start(5);
        send(24'h0B0000, 24'h0A0000, 24'hFFFFFF, 1, 0);
        send(24'h0A0001, 24'h0A0001, 24'hFFFFFF, 1, 0);
        tick(); tick();
        chk("t5_pre_fcnt", fail_count, 1);
        start = 1'b1; total_vectors = 5; res_valid = 1'b1; res_data = 24'h0A0002;
        tick();
        start = 1'b0; res_valid = 1'b0; idx = '0;
        chk("t5_clr_vec", vec_count, 0);
        chk("t5_clr_fcnt", fail_count, 0);
        chk("t5_clr_first", first_fail_idx, 16'hFFFF);
        chk("t5_busy", busy, 1);
        chk("t5_start_nopop", pops - p0, 2);
        for (int i = 2; i < 7; i++) send(24'h0A0000 + 24'(i), 24'h0A0000 + 24'(i), 24'hFFFFFF, 1, 0);
        wait_done(20);
        chk("t5_vec", vec_count, 5);
        chk("t5_pops", pops - p0, 7);
        send(24'h0A0007, 24'h0A0007, 24'hFFFFFF, 1, 1);
        send(24'h123456, 24'h0A0008, 24'hFFFFFF, 1, 1);
        tick(); tick(); tick();
        chk("t5_done_nopop", pops - p0, 7);
        chk("t5_done_vec", vec_count, 5);
        chk("t5_done_fcnt", fail_count, 0);
        chk("t5_done_hold", done, 1);
        chk("t5_sb_empty", sb.size(), 0);

        // total_vectors = 0 finishes the cycle after start
        do_start(0);
        chk("t6_busy", busy, 1);
        tick();
        chk("t6_done", done, 1);

        // reset while a mismatch sits in stage 1
        expq.delete();
        expq.push_back({24'hFFFFFF, 24'h000000});
        expq.push_back({24'hFFFFFF, 24'h000000});
        tick();
        p0 = pops;
        do_start(4);
        send(24'hDEAD00, 24'h0, 24'hFFFFFF, 1, 1);
        reset_n = 1'b0;
        #1;
        chk_reset_vals();
        tick(); tick();
        reset_n = 1'b1;
        send(24'h000000, 24'h0, 24'hFFFFFF, 1, 1);
        tick(); tick(); tick();
        chk_reset_vals();
        chk("t7_pops", pops - p0, 1);
        chk("t7_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
